// File: rtl/ahb_mtx_in_stage_pkg.sv
// Shared encodings and bundle types for the AHB matrix input stage.
// Imported by the RTL top and the bench.
package ahb_mtx_in_stage_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int ADDR_W  = 32;
  localparam int TRANS_W = 2;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;
  localparam int PROT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [TRANS_W-1:0] trans;
    logic               write;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [PROT_W-1:0]  prot;
    logic               mastlock;
  } ctrl_t;

endpackage

// File: rtl/ahb_mtx_in_stage.sv
// AHB matrix input stage: forwards a master's address phase to the
// output arbiters, holding it while the arbiter has not yet accepted.
module ahb_mtx_in_stage
  import ahb_mtx_in_stage_pkg::*;
(
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELS,
  input  logic [ADDR_W-1:0]   HADDRS,
  input  logic [TRANS_W-1:0]  HTRANSS,
  input  logic                HWRITES,
  input  logic [SIZE_W-1:0]   HSIZES,
  input  logic [BURST_W-1:0]  HBURSTS,
  input  logic [PROT_W-1:0]   HPROTS,
  input  logic                HMASTLOCKS,
  input  logic                HREADYS,
  output logic                HREADYOUTS,
  output logic                HRESPS,
  output logic                req_op,
  output logic [ADDR_W-1:0]   addr_op,
  output logic [TRANS_W-1:0]  trans_op,
  output logic                write_op,
  output logic [SIZE_W-1:0]   size_op,
  output logic [BURST_W-1:0]  burst_op,
  output logic [PROT_W-1:0]   prot_op,
  output logic                mastlock_op,
  input  logic                addr_accept,
  input  logic                data_ready,
  input  logic                data_resp
);

  state_e state_q;
  state_e state_d;
  state_e launch;
  ctrl_t  live;
  ctrl_t  hold_q;
  ctrl_t  fwd;
  logic   live_valid;
  logic   capture;

  assign live_valid = HSELS & HREADYS & HTRANSS[1];

  assign live = '{
    addr:     HADDRS,
    trans:    HTRANSS,
    write:    HWRITES,
    size:     HSIZES,
    burst:    HBURSTS,
    prot:     HPROTS,
    mastlock: HMASTLOCKS
  };

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Where a fresh live transfer goes, from IDLE or a finishing data phase
  always_comb begin
    launch = ST_IDLE;
    if (live_valid) begin
      launch = addr_accept ? ST_DATA : ST_PEND;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PEND: if (addr_accept) state_d = ST_DATA;
      ST_DATA: if (data_ready) state_d = launch;
      default: state_d = launch;
    endcase
  end

  assign capture = (state_d == ST_PEND) && (state_q != ST_PEND);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_q <= '0;
    end else if (capture) begin
      hold_q <= live;
    end
  end

  always_comb begin
    fwd        = live;
    req_op     = live_valid;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    unique case (1'b1)
      (state_q == ST_PEND): begin
        fwd        = hold_q;
        req_op     = 1'b1;
        HREADYOUTS = 1'b0;
      end
      (state_q == ST_DATA): begin
        HREADYOUTS = data_ready;
        HRESPS     = data_resp;
      end
      default: ;
    endcase
  end

  assign addr_op     = fwd.addr;
  assign trans_op    = fwd.trans;
  assign write_op    = fwd.write;
  assign size_op     = fwd.size;
  assign burst_op    = fwd.burst;
  assign prot_op     = fwd.prot;
  assign mastlock_op = fwd.mastlock;

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Scoreboard bench for ahb_mtx_in_stage: a transfer-level model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_ahb_mtx_in_stage;
  import ahb_mtx_in_stage_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        req_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic        write_op;
  logic [2:0]  size_op;
  logic [2:0]  burst_op;
  logic [3:0]  prot_op;
  logic        mastlock_op;
  logic        addr_accept;
  logic        data_ready;
  logic        data_resp;

  ahb_mtx_in_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .req_op(req_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
    .prot_op(prot_op), .mastlock_op(mastlock_op),
    .addr_accept(addr_accept), .data_ready(data_ready),
    .data_resp(data_resp)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [48:0] exp_q[$];
  ctrl_t       pend_q[$];
  bit          in_data;

  task automatic chk(input string name, input logic [48:0] act,
                     input logic [48:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, predict its outputs, then advance the model
  task automatic step(input logic rn, input logic sel, input logic hr,
                      input logic [1:0] t, input logic [31:0] a,
                      input logic w, input logic acc, input logic dr,
                      input logic drsp);
    ctrl_t       live;
    logic        lv;
    logic [48:0] e;
    @(posedge HCLK);
    #1;
    HRESETn     = rn;
    HSELS       = sel;
    HREADYS     = hr;
    HTRANSS     = t;
    HADDRS      = a;
    HWRITES     = w;
    HSIZES      = 3'($urandom);
    HBURSTS     = 3'($urandom);
    HPROTS      = 4'($urandom);
    HMASTLOCKS  = 1'($urandom);
    addr_accept = acc;
    data_ready  = dr;
    data_resp   = drsp;
    if (!rn) begin
      pend_q.delete();
      in_data = 0;
    end
    lv = sel & hr & (t == 2'b10 || t == 2'b11);
    live = '{addr: a, trans: t, write: w, size: HSIZES,
             burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};
    if (pend_q.size() > 0) e = {1'b1, 1'b0, 1'b0, pend_q[0]};
    else if (in_data) e = {lv, dr, drsp, live};
    else e = {lv, 1'b1, 1'b0, live};
    exp_q.push_back(e);
    if (rn) begin
      if (pend_q.size() > 0) begin
        if (acc) begin
          void'(pend_q.pop_front());
          in_data = 1;
        end
      end else if (!in_data || dr) begin
        in_data = lv && acc;
        if (lv && !acc) pend_q.push_back(live);
      end
    end
  endtask

  initial begin : monitor
    logic [48:0] act;
    logic [48:0] e;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {req_op, HREADYOUTS, HRESPS, addr_op, trans_op, write_op,
               size_op, burst_op, prot_op, mastlock_op};
        chk($sformatf("cycle%0d outputs", cyc), act, e);
      end
    end
  end

  initial begin : stim
    HRESETn = 0; HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0;
    HSIZES = 0; HBURSTS = 0; HPROTS = 0; HMASTLOCKS = 0; HREADYS = 1;
    addr_accept = 0; data_ready = 0; data_resp = 0;
    in_data = 0;
    step(0, 1, 1, HTRANS_IDLE, 0, 0, 0, 0, 0);
    step(0, 1, 1, HTRANS_NONSEQ, 32'h1234, 0, 0, 0, 0);
    #1 chk("reset req", 49'(req_op), 49'(1));
    chk("reset ready", 49'(HREADYOUTS), 49'(1));

    // direct accept
    step(1, 1, 1, HTRANS_NONSEQ, 32'h2000_0000, 0, 1, 0, 0);
    #1 chk("direct req", 49'(req_op), 49'(1));
    step(1, 1, 1, HTRANS_IDLE, 0, 0, 0, 1, 0);
    #1 chk("direct ready", 49'(HREADYOUTS), 49'(1));

    // hold while the arbiter stalls
    step(1, 1, 1, HTRANS_NONSEQ, 32'h4000_0010, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 2'($urandom), $urandom, 0, i == 2, 1, 0);
      #1 chk("hold addr", 49'(addr_op), 49'(32'h4000_0010));
      chk("hold write", 49'(write_op), 49'(1));
      chk("hold ready", 49'(HREADYOUTS), 49'(0));
    end

    // two-cycle error with back-to-back SEQ presented on its second cycle
    step(1, 1, 1, HTRANS_IDLE, 0, 0, 0, 0, 1);
    #1 chk("err1 resp", 49'(HRESPS), 49'(1));
    chk("err1 ready", 49'(HREADYOUTS), 49'(0));
    step(1, 1, 1, HTRANS_SEQ, 32'h0000_0104, 0, 0, 1, 1);
    #1 chk("err2 resp", 49'(HRESPS), 49'(1));
    chk("err2 ready", 49'(HREADYOUTS), 49'(1));
    step(1, 1, 1, HTRANS_IDLE, 0, 0, 0, 1, 0);
    #1 chk("b2b addr", 49'(addr_op), 49'(32'h0000_0104));
    chk("b2b trans", 49'(trans_op), 49'(2'b11));

    // reset while pending
    step(0, 1, 1, HTRANS_IDLE, 0, 0, 0, 0, 0);
    #1 chk("rst req", 49'(req_op), 49'(0));
    chk("rst ready", 49'(HREADYOUTS), 49'(1));
    step(1, 1, 1, HTRANS_IDLE, 0, 0, 1, 1, 0);

    // BUSY and IDLE never request
    step(1, 1, 1, HTRANS_BUSY, 32'h55, 0, 0, 1, 0);
    #1 chk("busy req", 49'(req_op), 49'(0));
    step(1, 1, 1, HTRANS_IDLE, 32'h66, 0, 0, 1, 0);
    #1 chk("busy ready", 49'(HREADYOUTS), 49'(1));
    chk("busy resp", 49'(HRESPS), 49'(0));

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) != 0, 2'($urandom), $urandom,
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0);
    end

    repeat (3) @(negedge HCLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_in_stage.md
AHB_MTX_IN_STAGE -- requirements
Module: ahb_mtx_in_stage

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first: HCLK in 1 clock; HRESETn in 1 asynchronous active-low reset.
REQ-002 SHALL have master-side inputs: HSELS in 1 select; HADDRS in 32 address; HTRANSS in 2 transfer type; HWRITES in 1 write; HSIZES in 3 size; HBURSTS in 3 burst; HPROTS in 4 protection; HMASTLOCKS in 1 lock; HREADYS in 1 bus ready.
REQ-003 SHALL have master-side outputs: HREADYOUTS out 1 ready to master; HRESPS out 1 response to master (0 OKAY, 1 ERROR).
REQ-004 SHALL have matrix-side outputs: req_op out 1 request to output arbiters; addr_op out 32; trans_op out 2; write_op out 1; size_op out 3; burst_op out 3; prot_op out 4; mastlock_op out 1.
REQ-005 SHALL have matrix-side inputs: addr_accept in 1 (owning arbiter selected this port and HREADYM=1 this cycle); data_ready in 1 slave HREADYOUT for this port's data phase; data_resp in 1 slave HRESP for that data phase.

Function
REQ-006 SHALL define live_valid = HSELS & HREADYS & HTRANSS[1] (NONSEQ 2'b10 or SEQ 2'b11); IDLE/BUSY never generate a request.
REQ-007 SHALL implement FSM states IDLE, PEND, DATA.
REQ-008 IDLE: live_valid & addr_accept -> DATA; live_valid & ~addr_accept -> capture live address/control into hold register, -> PEND; else stay.
REQ-009 PEND: addr_accept -> DATA, hold register remains valid until that edge; else stay; live inputs ignored.
REQ-010 DATA: data_ready=0 -> stay; data_ready=1 applies REQ-008 transition rules to the current live inputs (back-to-back pipelining).
REQ-011 SHALL drive matrix-side outputs from hold register when state=PEND, else from live inputs, zero cycle latency.
REQ-012 SHALL drive req_op = 1 in PEND; otherwise req_op = live_valid.
REQ-013 SHALL drive HREADYOUTS = 1 in IDLE, 0 in PEND, data_ready in DATA.
REQ-014 SHALL drive HRESPS = data_resp in DATA, 0 in IDLE and PEND.
REQ-015 Two-cycle ERROR: data_resp=1 with data_ready=0 then 1 SHALL be passed through unchanged; a new transfer presented in the second ERROR cycle SHALL be handled per REQ-010.
REQ-016 Hold register SHALL capture only when the FSM enters PEND; at no other time.
REQ-017 A live transfer with HSELS=0 or HREADYS=0 SHALL neither be captured nor requested.
REQ-018 Simultaneous data_ready=1 and live_valid with addr_accept=0 in DATA SHALL capture and enter PEND in the same edge.
REQ-019 Hold register SHALL preserve HMASTLOCKS so mastlock_op stays asserted during PEND.

Reset
REQ-020 HRESETn low SHALL asynchronously force state=IDLE and hold register to zero; HREADYOUTS=1, HRESPS=0, req_op=live_valid.
REQ-021 Reset asserted in PEND or DATA SHALL discard the held/in-flight transfer, with no request after reset release until a new live_valid.

Structure
REQ-022 Shared package SHALL hold HTRANS encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11), HRESP encodings, FSM state encoding, and hold-register field widths.
REQ-023 SHALL be a single module with no sub-module; one FSM process, one hold register process, combinational output muxes.

Verification
REQ-024 Direct accept: NONSEQ HADDRS=0x2000_0000 with addr_accept=1, data_ready=1 next cycle -> req_op=1 same cycle, HREADYOUTS=1, state IDLE->DATA->IDLE.
REQ-025 Hold: NONSEQ write HADDRS=0x4000_0010 with addr_accept=0 for 3 cycles then 1 -> addr_op=0x4000_0010 and write_op=1 during PEND although HADDRS changes, HREADYOUTS=0 for 3 cycles.
REQ-026 Wait/Error: in DATA data_resp=1, data_ready=0 then 1 -> HRESPS=1 for both cycles, HREADYOUTS 0 then 1.
REQ-027 Back-to-back: SEQ to 0x0000_0104 presented on completing data phase with addr_accept=0 -> PEND next cycle, hold=0x0000_0104, trans_op=2'b11.
REQ-028 Reset in PEND: HRESETn low mid-cycle -> state IDLE immediately, req_op=0 with HTRANSS=IDLE, HREADYOUTS=1.
REQ-029 IDLE/BUSY with HSELS=1 -> req_op=0, no capture, HREADYOUTS=1, HRESPS=0.
